// File: rtl/apb_pkg.sv
// Shared types for the APB request arbiter: FSM states, master opcodes and a wrap-around adder.
package apb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DRAIN
    } arb_state_t;

    localparam logic [1:0] APB_OP_NOP   = 2'b00;
    localparam logic [1:0] APB_OP_READ  = 2'b01;
    localparam logic [1:0] APB_OP_WRITE = 2'b11;

    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Purpose: round-robin pick of the first valid requester at or above rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
module apb_rr_picker
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_valid
);

    logic [IW-1:0] idx;

    // Scan offsets from far to near so the nearest valid requester is written last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'(wrap_add(32'(rr_ptr), 32'(k), 32'(NUM_REQ)));
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Purpose: share one APB master among NUM_REQ requesters, one transfer per round-robin grant.
// Latency: accept to rsp_valid_o is 4 cycles with a zero-wait slave; timeout after TIMEOUT WAIT cycles.
// Backpressure: requesters hold req_valid_i until req_ack_o; new grants only while IDLE.
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ-1:0]      req_write_i,
    input  logic [NUM_REQ-1:0][31:0] req_wdata_i,
    output logic [NUM_REQ-1:0]      req_ack_o,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    output logic [31:0]             rsp_rdata_o,
    output logic                    rsp_error_o,
    output logic [1:0]              add_o,
    output logic [31:0]             wdata_o,
    input  logic                    ready_i,
    input  logic [31:0]             rdata_i,
    output logic                    busy_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] rr_ptr, gnt_idx, gnt_q;
    logic          gnt_vld, write_q;
    logic [CW-1:0] tmo_cnt;
    logic          accept, done_ok, done_tmo;

    apb_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
        .req         (req_valid_i),
        .rr_ptr      (rr_ptr),
        .grant_idx   (gnt_idx),
        .grant_valid (gnt_vld)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ack_o = '0;
        add_o     = APB_OP_NOP;
        accept    = 1'b0;
        done_ok   = 1'b0;
        done_tmo  = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                // Acks are combinational, so mask them while reset holds the FSM in IDLE.
                if (gnt_vld && !preset) begin
                    accept    = 1'b1;
                    req_ack_o = NUM_REQ'(1) << gnt_idx;
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                add_o     = write_q ? APB_OP_WRITE : APB_OP_READ;
                state_nxt = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (ready_i) begin
                    done_ok   = 1'b1;
                    state_nxt = ARB_IDLE;
                end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                    done_tmo  = 1'b1;
                    state_nxt = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (ready_i) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rr_ptr      <= '0;
            gnt_q       <= '0;
            write_q     <= 1'b0;
            wdata_o     <= '0;
            tmo_cnt     <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b0;
        end else begin
            rsp_valid_o <= '0;
            if (accept) begin
                gnt_q   <= gnt_idx;
                write_q <= req_write_i[gnt_idx];
                wdata_o <= req_wdata_i[gnt_idx];
                rr_ptr  <= IW'(wrap_add(32'(gnt_idx), 1, 32'(NUM_REQ)));
            end
            tmo_cnt <= (state == ARB_WAIT && !done_ok && !done_tmo) ? tmo_cnt + 1'b1 : '0;
            if (done_ok) begin
                rsp_valid_o <= NUM_REQ'(1) << gnt_q;
                rsp_rdata_o <= write_q ? '0 : rdata_i;
                rsp_error_o <= 1'b0;
            end else if (done_tmo) begin
                rsp_valid_o <= NUM_REQ'(1) << gnt_q;
                rsp_rdata_o <= '0;
                rsp_error_o <= 1'b1;
            end
        end
    end

    assign busy_o = (state != ARB_IDLE);

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: a stub APB master/slave answers two cycles after each command;
// a transaction-level model predicts grant order, timing and response data.
module tb_apb_req_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic                pclk = 1'b0;
    logic                preset;
    logic [N-1:0]        req_valid_i, req_write_i;
    logic [N-1:0][31:0]  req_wdata_i;
    logic [N-1:0]        req_ack_o, rsp_valid_o;
    logic [31:0]         rsp_rdata_o;
    logic                rsp_error_o;
    logic [1:0]          add_o;
    logic [31:0]         wdata_o;
    logic                ready_i;
    logic [31:0]         rdata_i;
    logic                busy_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state
    int          rr_m;
    logic [N-1:0] pend, wr_m;
    logic [31:0] wd_m [N];
    logic [31:0] mem_m;

    // stub master/slave state
    logic [31:0] slave_reg;
    bit          stall = 1'b0;
    bit          force_rdy = 1'b0;
    int          cdown;
    bit          op_w;

    apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .req_valid_i (req_valid_i),
        .req_write_i (req_write_i),
        .req_wdata_i (req_wdata_i),
        .req_ack_o   (req_ack_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .add_o       (add_o),
        .wdata_o     (wdata_o),
        .ready_i     (ready_i),
        .rdata_i     (rdata_i),
        .busy_o      (busy_o)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    // Command seen in cycle C -> ready_i during cycle C+2 (master SETUP then ACCESS).
    initial begin
        ready_i = 1'b0; rdata_i = '0; cdown = 0; slave_reg = '0; op_w = 1'b0;
        forever begin
            @(negedge pclk);
            ready_i = force_rdy;
            rdata_i = $urandom;
            if (preset) begin
                cdown = 0;
            end else begin
                if (cdown > 0) begin
                    cdown--;
                    if (cdown == 0 && !stall) begin
                        ready_i = 1'b1;
                        if (op_w) slave_reg = wdata_o;
                        else      rdata_i = slave_reg;
                    end
                end
                if (add_o != 2'b00) begin
                    op_w  = add_o[1];
                    cdown = 2;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge pclk);
        #1;
    endtask

    function automatic int model_pick();
        for (int k = 0; k < N; k++)
            if (pend[(rr_m + k) % N]) return (rr_m + k) % N;
        return 0;
    endfunction

    task automatic set_req(input int i, input bit w, input logic [31:0] d);
        pend[i] = 1'b1; wr_m[i] = w; wd_m[i] = d;
        req_valid_i[i] = 1'b1; req_write_i[i] = w; req_wdata_i[i] = d;
    endtask

    // Called with the DUT idle and at least one request pending; returns at the response cycle.
    task automatic xfer(output int g, output int acc_cyc);
        int eg;
        #1;
        eg = model_pick();
        chk("ack", 32'(req_ack_o), 32'(1) << eg);
        chk("busy_idle", 32'(busy_o), 0);
        g = eg; acc_cyc = cyc;
        rr_m = (eg + 1) % N;
        pend[eg] = 1'b0;
        step();                                   // T+1
        req_valid_i[eg] = 1'b0;
        req_wdata_i[eg] = '0;
        chk("add_cmd", 32'(add_o), wr_m[eg] ? 32'd3 : 32'd1);
        chk("wdata_lat", wdata_o, wd_m[eg]);
        chk("ack_clr", 32'(req_ack_o), 0);
        chk("busy", 32'(busy_o), 1);
        step(); step();                           // T+3
        chk("add_nop", 32'(add_o), 0);
        chk("wdata_hold", wdata_o, wd_m[eg]);
        chk("rsp_early", 32'(rsp_valid_o), 0);
        step();                                   // T+4
        chk("rsp_vld", 32'(rsp_valid_o), 32'(1) << eg);
        chk("rsp_err", 32'(rsp_error_o), 0);
        chk("rsp_data", rsp_rdata_o, wr_m[eg] ? 32'd0 : mem_m);
        if (wr_m[eg]) mem_m = wd_m[eg];
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"},   32'(req_ack_o), 0);
        chk({tag, "_rspv"},  32'(rsp_valid_o), 0);
        chk({tag, "_rdata"}, rsp_rdata_o, 0);
        chk({tag, "_err"},   32'(rsp_error_o), 0);
        chk({tag, "_add"},   32'(add_o), 0);
        chk({tag, "_wdata"}, wdata_o, 0);
        chk({tag, "_busy"},  32'(busy_o), 0);
    endtask

    initial begin
        int g, ac, prev_ac, eg;
        preset = 1'b1;
        req_valid_i = '0; req_write_i = '0; req_wdata_i = '0;
        pend = '0; wr_m = '0; rr_m = 0; mem_m = '0;
        for (int i = 0; i < N; i++) wd_m[i] = '0;
        step(); step();
        chk_zero("rst");
        preset = 1'b0;
        step();

        // all four at once: strict order 0..3, 4 cycles apart
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h1000 + i);
        prev_ac = 0;
        for (int i = 0; i < N; i++) begin
            xfer(g, ac);
            if (i > 0) chk("gap", 32'(ac - prev_ac), 4);
            prev_ac = ac;
        end
        set_req(0, 1'b0, $urandom);
        xfer(g, ac);
        chk("final_rd", rsp_rdata_o, 32'h1003);

        // wrap: grant 3, then 0 and 2 pending -> 0 first
        set_req(3, 1'b0, $urandom);
        xfer(g, ac);
        set_req(0, 1'b0, $urandom);
        set_req(2, 1'b1, 32'h0BAD_F00D);
        xfer(g, ac);
        xfer(g, ac);

        // single write then read on requester 0
        set_req(0, 1'b1, 32'hDEAD_BEEF);
        xfer(g, ac);
        set_req(0, 1'b0, $urandom);
        xfer(g, ac);
        chk("wr_rd", rsp_rdata_o, 32'hDEAD_BEEF);

        // write data stability: request data zeroed one cycle after ack
        set_req(1, 1'b1, 32'hA5A5_A5A5);
        xfer(g, ac);
        chk("slave_wdata", slave_reg, 32'hA5A5_A5A5);
        set_req(1, 1'b0, $urandom);
        xfer(g, ac);

        // timeout with no ready, then drain
        stall = 1'b1;
        set_req(2, 1'b0, $urandom);
        #1;
        eg = model_pick();
        chk("tmo_ack", 32'(req_ack_o), 32'(1) << eg);
        rr_m = (eg + 1) % N; pend[eg] = 1'b0;
        for (int k = 1; k <= TMO + 1; k++) begin
            step();
            if (k == 1) req_valid_i[eg] = 1'b0;
            chk("tmo_quiet", 32'(rsp_valid_o), 0);
            if (k >= 2) chk("tmo_nop", 32'(add_o), 0);
        end
        step();
        chk("tmo_vld", 32'(rsp_valid_o), 32'(1) << eg);
        chk("tmo_err", 32'(rsp_error_o), 1);
        chk("tmo_rdata", rsp_rdata_o, 0);
        chk("tmo_busy", 32'(busy_o), 1);
        set_req(0, 1'b0, $urandom);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("drain_busy", 32'(busy_o), 1);
            chk("drain_ack", 32'(req_ack_o), 0);
            chk("drain_rsp", 32'(rsp_valid_o), 0);
        end
        force_rdy = 1'b1;
        step();
        force_rdy = 1'b0;
        stall = 1'b0;
        chk("drain_rsp2", 32'(rsp_valid_o), 0);
        step();
        chk("late_rsp", 32'(rsp_valid_o), 0);
        chk("drain_exit", 32'(busy_o), 0);
        xfer(g, ac);

        // reset asserted while waiting on a read
        set_req(1, 1'b0, $urandom);
        #1;
        eg = model_pick();
        chk("rstw_ack", 32'(req_ack_o), 32'(1) << eg);
        pend[eg] = 1'b0;
        step();
        req_valid_i[eg] = 1'b0;
        step();
        preset = 1'b1;
        set_req(2, 1'b0, $urandom);
        set_req(0, 1'b1, 32'h5555_0000);
        #1;
        chk_zero("rstw");
        step();
        chk_zero("rstw2");
        rr_m = 0;
        preset = 1'b0;
        xfer(g, ac);
        xfer(g, ac);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            if (pend == '0) begin
                if ($urandom_range(0, 1) == 1) begin step(); step(); end
                set_req($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), $urandom);
            end
            xfer(g, ac);
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
